// File: rtl/fifo_pixel_reader.sv
// fifo_pixel_reader
//   Read-side master for the capture FIFO. Pops words with fifo_rd/fifo_empty,
//   absorbs the FIFO's one-cycle read latency in a two-entry skid buffer, and
//   streams the words on a valid/ready port tagged with SOL/EOL/EOF markers.
//
// Ports
//   Pclk        clock, all logic rising-edge
//   rst         synchronous active-high reset
//   enable      start/continue frames, sampled at frame boundaries only
//   fifo_empty  FIFO empty flag (registered)
//   fifo_data   FIFO read data, valid the cycle after fifo_rd
//   fifo_rd     FIFO pop strobe
//   out_data    stream data
//   out_valid   stream valid
//   out_ready   stream ready from the consumer
//   out_sol     first word of a line
//   out_eol     last word of a line
//   out_eof     last word of a frame (together with out_eol)
//   frame_done  one-cycle pulse after the EOF word is accepted
//   underrun    sticky starvation flag
//
// Optional feature: define FIFO_READER_TIMEOUT_EN to enable the mid-frame
// underrun timeout. Without it the reader waits indefinitely and underrun is 0.
module fifo_pixel_reader #(
  parameter int DATA_W      = 10,
  parameter int LINE_WORDS  = 320,
  parameter int FRAME_LINES = 240,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              Pclk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sol,
  output logic              out_eol,
  output logic              out_eof,
  output logic              frame_done,
  output logic              underrun
);

  localparam int COL_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int LIN_W = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
  localparam int TOTAL = LINE_WORDS * FRAME_LINES;
  localparam int ISS_W = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic              vld_p1;            // a pop issued last cycle: fifo_data valid now
  logic [1:0]        occ;               // skid buffer occupancy
  logic [DATA_W-1:0] buf0_p2, buf1_p2;  // buf0_p2 is the head
  logic [COL_W-1:0]  col;
  logic [LIN_W-1:0]  line;
  logic [ISS_W-1:0]  words_issued;
  logic              accept, last_col, last_line, eof_accept, room, timeout_fire;

  assign last_col   = (col == COL_W'(LINE_WORDS - 1));
  assign last_line  = (line == LIN_W'(FRAME_LINES - 1));

  // Stream side: the head of the buffer, or the word arriving from the FIFO
  // this cycle when the buffer is empty (keeps pop-to-valid latency at one).
  assign out_valid  = (occ != 2'd0) | vld_p1;
  assign out_data   = (occ != 2'd0) ? buf0_p2 : (vld_p1 ? fifo_data : '0);
  assign accept     = out_valid & out_ready;
  assign out_sol    = out_valid & (col == '0);
  assign out_eol    = out_valid & last_col;
  assign out_eof    = out_valid & last_col & last_line;
  assign eof_accept = accept & last_col & last_line;
  assign frame_done = (state == DONE);

  // Only pop when every word already owed to us still fits in the buffer.
  assign room    = (occ == 2'd0) | ((occ == 2'd1) & ~vld_p1);
  assign fifo_rd = (state == RUN) & ~fifo_empty & room &
                   (words_issued < ISS_W'(TOTAL));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (eof_accept) state_nxt = DONE;
      DONE:    state_nxt = enable ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (timeout_fire) state_nxt = IDLE;
  end

  always_ff @(posedge Pclk) begin
    if (rst) begin
      state        <= IDLE;
      vld_p1       <= 1'b0;
      occ          <= 2'd0;
      col          <= '0;
      line         <= '0;
      words_issued <= '0;
    end else begin
      state  <= state_nxt;
      vld_p1 <= fifo_rd;
      if (timeout_fire) begin
        occ          <= 2'd0;
        col          <= '0;
        line         <= '0;
        words_issued <= '0;
      end else begin
        if (vld_p1 & ~accept)      occ <= occ + 2'd1;
        else if (~vld_p1 & accept) occ <= occ - 2'd1;

        if (accept) begin
          if (last_col) begin
            col  <= '0;
            line <= last_line ? '0 : line + LIN_W'(1);
          end else begin
            col <= col + COL_W'(1);
          end
        end

        if (state == DONE)  words_issued <= '0;
        else if (fifo_rd)   words_issued <= words_issued + ISS_W'(1);
      end
    end
  end

  // ---- stage p1 -> p2: capture FIFO read data into the skid buffer ----
  always_ff @(posedge Pclk) begin
    if (vld_p1) begin
      if (occ == 2'd0)  buf0_p2 <= fifo_data;
      else if (accept)  buf0_p2 <= fifo_data;
      else              buf1_p2 <= fifo_data;
    end else if (accept && occ == 2'd2) begin
      buf0_p2 <= buf1_p2;
    end
  end

`ifdef FIFO_READER_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMR_W-1:0] tmr;
  logic             underrun_r;
  logic             starving;

  // Only counts once a frame is under way; waiting for the first word is fine.
  assign starving     = (state == RUN) & ((col != '0) | (line != '0)) & ~fifo_rd;
  assign timeout_fire = starving & (tmr == TMR_W'(TIMEOUT_CYC - 1));
  assign underrun     = underrun_r;

  always_ff @(posedge Pclk) begin
    if (rst) begin
      tmr        <= '0;
      underrun_r <= 1'b0;
    end else if (timeout_fire) begin
      tmr        <= '0;
      underrun_r <= 1'b1;
    end else if (starving) begin
      tmr <= tmr + TMR_W'(1);
    end else begin
      tmr <= '0;
    end
  end
`else
  logic [31:0] unused_timeout_cfg;

  // Keeps the timeout parameter referenced in builds without the timeout.
  assign unused_timeout_cfg = 32'(TIMEOUT_CYC);
  assign timeout_fire       = 1'b0;
  assign underrun           = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_pixel_reader.sv
module tb_fifo_pixel_reader;
  localparam int DATA_W = 10;
  localparam int LW     = 4;
  localparam int FL     = 2;
  localparam int TO     = 16;
`ifdef FIFO_READER_TIMEOUT_EN
  localparam int STARVE = 12;
`else
  localparam int STARVE = 20;
`endif

  logic              Pclk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic              fifo_empty = 1'b1;
  logic [DATA_W-1:0] fifo_data = '0;
  logic              fifo_rd;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              out_sol, out_eol, out_eof, frame_done, underrun;

  fifo_pixel_reader #(
    .DATA_W(DATA_W), .LINE_WORDS(LW), .FRAME_LINES(FL), .TIMEOUT_CYC(TO)
  ) dut (
    .Pclk(Pclk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_rd(fifo_rd), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sol(out_sol),
    .out_eol(out_eol), .out_eof(out_eof), .frame_done(frame_done),
    .underrun(underrun)
  );

  always #5 Pclk = ~Pclk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Capture FIFO model: registered empty flag, data one cycle after a pop.
  logic [DATA_W-1:0] mem[$];
  logic [DATA_W-1:0] pending[$];
  logic [DATA_W-1:0] expq[$];

  always @(posedge Pclk) begin
    if (rst) begin
      mem.delete();
      pending.delete();
      fifo_empty <= 1'b1;
    end else begin
      if (fifo_rd && mem.size() > 0) fifo_data <= mem.pop_front();
      while (pending.size() > 0) mem.push_back(pending.pop_front());
      fifo_empty <= (mem.size() == 0);
    end
  end

  // Stream model: words leave in push order; markers follow the word's
  // position inside the frame.
  logic              rst_q = 1'b1;
  int                idx = 0, beats = 0, pops = 0, frames = 0;
  bit                fd_exp = 0, stall = 0, ur_q = 0;
  logic [DATA_W-1:0] st_data;
  logic [2:0]        st_mk;
  logic [7:0]        sol_mask, eol_mask, eof_mask;
  logic [DATA_W-1:0] log_d[$];

  always @(posedge Pclk) rst_q <= rst;

  always @(negedge Pclk) begin
    if (rst_q) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_fifo_rd", fifo_rd, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_out_data", out_data, 0);
      check("rst_markers", {out_sol, out_eol, out_eof}, 0);
      check("rst_underrun", underrun, 0);
      expq.delete();
      idx = 0; fd_exp = 0; stall = 0; ur_q = 0;
    end else begin
      check("frame_done", frame_done, fd_exp);
      fd_exp = 0;
      check("rd_while_empty", fifo_rd & fifo_empty, 0);
      if (fifo_rd) pops++;
`ifndef FIFO_READER_TIMEOUT_EN
      check("underrun_tied", underrun, 0);
`else
      if (underrun && !ur_q) idx = 0;
      ur_q = underrun;
`endif
      if (stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, st_data);
        check("stall_markers", {out_sol, out_eol, out_eof}, st_mk);
      end
      if (out_valid) begin
        if (expq.size() == 0) begin
          check("unexpected_beat", out_valid, 0);
        end else begin
          check("beat_data", out_data, expq[0]);
          check("beat_sol", out_sol, idx % LW == 0);
          check("beat_eol", out_eol, idx % LW == LW - 1);
          check("beat_eof", out_eof, idx == LW * FL - 1);
          if (out_ready) begin
            if (beats < 8) begin
              sol_mask[beats] = out_sol;
              eol_mask[beats] = out_eol;
              eof_mask[beats] = out_eof;
            end
            log_d.push_back(out_data);
            beats++;
            void'(expq.pop_front());
            if (idx == LW * FL - 1) begin
              fd_exp = 1; frames++; idx = 0;
            end else begin
              idx++;
            end
          end
        end
        stall   = !out_ready;
        st_data = out_data;
        st_mk   = {out_sol, out_eol, out_eof};
      end else begin
        stall = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Pclk);
      #2;
    end
  endtask

  task automatic push(input logic [DATA_W-1:0] w);
    pending.push_back(w);
    expq.push_back(w);
  endtask

  task automatic do_reset;
    rst = 1'b1; enable = 1'b0; out_ready = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic clear_log;
    beats = 0; pops = 0; frames = 0;
    sol_mask = '0; eol_mask = '0; eof_mask = '0;
    log_d.delete();
  endtask

  task automatic start_frame;
    enable = 1'b1;
    tick(1);
    enable = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget, input bit toggle, input string name);
    int k = 0;
    while (frames < n && k < budget) begin
      if (toggle) out_ready = ~out_ready;
      tick(1);
      k++;
    end
    check({name, "_frame_timeout"}, frames >= n, 1);
  endtask

  initial begin
    // 1: reset, then idle with enable low
    tick(3);
    rst = 1'b0;
    tick(2);
    for (int i = 0; i < 10; i++) begin
      check("t1_fifo_rd", fifo_rd, 0);
      check("t1_out_valid", out_valid, 0);
      check("t1_frame_done", frame_done, 0);
      check("t1_out_data", out_data, 0);
      tick(1);
    end

    // 2: full frame, consumer always ready
    do_reset; clear_log;
    for (int i = 1; i <= 8; i++) push(10'(i));
    out_ready = 1'b1;
    start_frame;
    wait_frames(1, 100, 0, "t2");
    tick(4);
    check("t2_pops", pops, 8);
    check("t2_beats", beats, 8);
    check("t2_sol_mask", sol_mask, 8'h11);
    check("t2_eol_mask", eol_mask, 8'h88);
    check("t2_eof_mask", eof_mask, 8'h80);
    check("t2_first", log_d.size() > 0 ? log_d[0] : 10'h3ff, 10'h001);
    check("t2_last", log_d.size() > 7 ? log_d[7] : 10'h3ff, 10'h008);

    // 3: toggling ready, a ninth word must stay in the FIFO
    do_reset; clear_log;
    for (int i = 1; i <= 9; i++) push(10'(i));
    out_ready = 1'b1;
    start_frame;
    wait_frames(1, 200, 1, "t3");
    out_ready = 1'b1;
    tick(6);
    check("t3_pops", pops, 8);
    check("t3_beats", beats, 8);
    check("t3_ninth_left", fifo_empty, 0);
    check("t3_eof_mask", eof_mask, 8'h80);
    for (int i = 0; i < 8; i++)
      check("t3_order", log_d.size() > i ? log_d[i] : 10'h3ff, 10'(i + 1));

    // 4: starvation after word 3, then refill
    do_reset; clear_log;
    for (int i = 1; i <= 3; i++) push(10'(i));
    out_ready = 1'b1;
    start_frame;
    tick(STARVE);
    check("t4_beats_starved", beats, 3);
    check("t4_pops_starved", pops, 3);
    check("t4_valid_starved", out_valid, 0);
    for (int i = 4; i <= 8; i++) push(10'(i));
    wait_frames(1, 100, 0, "t4");
    tick(4);
    check("t4_word4", log_d.size() > 3 ? log_d[3] : 10'h3ff, 10'h004);
    check("t4_eol_mask", eol_mask, 8'h88);
    check("t4_pops", pops, 8);

    // 5: reset mid-frame, next frame restarts cleanly
    do_reset; clear_log;
    for (int i = 1; i <= 8; i++) push(10'(32 + i));
    out_ready = 1'b1;
    start_frame;
    begin
      int k = 0;
      while (beats < 5 && k < 100) begin tick(1); k++; end
    end
    check("t5_reach5", beats >= 5, 1);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    clear_log;
    for (int i = 1; i <= 8; i++) push(10'(48 + i));
    start_frame;
    wait_frames(1, 100, 0, "t5");
    tick(4);
    check("t5_first", log_d.size() > 0 ? log_d[0] : 10'h3ff, 10'h031);
    check("t5_sol_mask", sol_mask, 8'h11);
    check("t5_eof_mask", eof_mask, 8'h80);
    check("t5_beats", beats, 8);
    check("t5_pops", pops, 8);

`ifdef FIFO_READER_TIMEOUT_EN
    // 6: starved mid-line past the timeout
    do_reset; clear_log;
    push(10'h001); push(10'h002);
    out_ready = 1'b1;
    start_frame;
    tick(10);
    check("t6_no_underrun_yet", underrun, 0);
    tick(20);
    check("t6_underrun", underrun, 1);
    check("t6_valid", out_valid, 0);
    push(10'h003);
    tick(5);
    check("t6_idle_no_pop", pops, 2);
    check("t6_sticky", underrun, 1);
    do_reset;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
